// File: rtl/clkspec_gcd_pkg.sv
// Shared definitions for the handshaked GCD unit.
//   state_t   : FSM state encoding (3 bits, undefined codes recover to IDLE)
//   DEF_WIDTH : default operand/result width
//   DEF_CNT_W : default width of the per-result modulus-operation counter
//   sat_inc   : increment that sticks at the all-ones value of a w-bit field
package clkspec_gcd_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CNT_W = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SEND  = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      SWAP  = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Saturating increment of a value held in a w-bit field (w <= 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] max_v;
      max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v >= max_v) ? max_v : (v + 32'd1);
   endfunction

endpackage

// File: rtl/clkspec_hs_gate_n.sv
// Handshake data gate: forces a data bus to zero whenever its valid is low,
// so idle buses never leak stale register contents.
//   valid : qualifier of the bus
//   din   : raw data from the owning register
//   dout  : din when valid=1, otherwise all zeros
module clkspec_hs_gate_n #(
   parameter int WIDTH = 8
) (
   input  logic             valid,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   assign dout = valid ? din : '0;

endmodule

// File: rtl/clkspec_gcd_hs_n.sv
// Unsigned GCD by repeated remainder, using an external handshaked modulus
// unit. One operation is in flight at a time.
//   clk, reset                   : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready, a, b      : operand handshake
//   mod_req_valid/ready, dd, dv  : modulus request (dividend, divisor)
//   mod_rsp_valid/ready, rm      : modulus response (remainder)
//   out_valid/out_ready, dout    : GCD result handshake
//   iters                        : modulus operations issued for this result (saturating)
// All outputs decode from the state and datapath registers only.
module clkspec_gcd_hs_n
   import clkspec_gcd_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             mod_req_valid,
   input  logic             mod_req_ready,
   output logic [WIDTH-1:0] dd,
   output logic [WIDTH-1:0] dv,
   input  logic             mod_rsp_valid,
   output logic             mod_rsp_ready,
   input  logic [WIDTH-1:0] rm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] iters
);

   state_t           state;
   logic [WIDTH-1:0] areg;
   logic [WIDTH-1:0] breg;
   logic [CNT_W-1:0] cnt;

   // Order the operands so the dividend is never smaller than the divisor.
   logic             a_ge_b;
   logic [WIDTH-1:0] op_max;
   logic [WIDTH-1:0] op_min;

   assign a_ge_b = (a >= b);
   assign op_max = a_ge_b ? a : b;
   assign op_min = a_ge_b ? b : a;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         areg  <= '0;
         breg  <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  cnt  <= '0;
                  areg <= op_max;
                  if (op_min == '0) begin
                     // gcd(x,0)=x and gcd(0,0)=0 without touching the modulus unit
                     breg  <= op_max;
                     state <= DONE;
                  end else begin
                     breg  <= op_min;
                     state <= SEND;
                  end
               end
            end
            SEND: begin
               if (mod_req_ready) begin
                  cnt   <= CNT_W'(sat_inc(32'(cnt), CNT_W));
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (mod_rsp_valid) begin
                  areg  <= rm;
                  state <= CHECK;
               end
            end
            CHECK: begin
               state <= (areg == '0) ? DONE : SWAP;
            end
            SWAP: begin
               // old divisor becomes the dividend, remainder becomes the divisor
               areg  <= breg;
               breg  <= areg;
               state <= SEND;
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready      = (state == IDLE);
   assign mod_req_valid = (state == SEND);
   assign mod_rsp_ready = (state == WAIT);
   assign out_valid     = (state == DONE);

   clkspec_hs_gate_n #(.WIDTH(WIDTH)) u_gate_dd (
      .valid (mod_req_valid),
      .din   (areg),
      .dout  (dd)
   );

   clkspec_hs_gate_n #(.WIDTH(WIDTH)) u_gate_dv (
      .valid (mod_req_valid),
      .din   (breg),
      .dout  (dv)
   );

   clkspec_hs_gate_n #(.WIDTH(WIDTH)) u_gate_dout (
      .valid (out_valid),
      .din   (breg),
      .dout  (dout)
   );

   clkspec_hs_gate_n #(.WIDTH(CNT_W)) u_gate_iters (
      .valid (out_valid),
      .din   (cnt),
      .dout  (iters)
   );

endmodule

// File: tb/tb_clkspec_gcd_hs_n.sv
// Directed bench for clkspec_gcd_hs_n (WIDTH=32, CNT_W=2 so the iteration
// counter saturates within a short run). A behavioural modulus unit with
// programmable request stall and response delay answers the DUT.
module tb_clkspec_gcd_hs_n;

   localparam int W = 32;
   localparam int C = 2;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         mod_req_valid;
   logic         mod_req_ready;
   logic [W-1:0] dd;
   logic [W-1:0] dv;
   logic         mod_rsp_valid;
   logic         mod_rsp_ready;
   logic [W-1:0] rm;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] dout;
   logic [C-1:0] iters;

   int tests_run;
   int tests_failed;
   int req_stall;
   int rsp_delay;
   int req_cnt_r;
   int rsp_cnt_r;

   logic [W-1:0] gd;
   logic [W-1:0] fdd;
   logic [W-1:0] fdv;
   logic [C-1:0] gi;
   int           lat;
   int           nreq;
   int           bad;

   clkspec_gcd_hs_n #(.WIDTH(W), .CNT_W(C)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .a             (a),
      .b             (b),
      .mod_req_valid (mod_req_valid),
      .mod_req_ready (mod_req_ready),
      .dd            (dd),
      .dv            (dv),
      .mod_rsp_valid (mod_rsp_valid),
      .mod_rsp_ready (mod_rsp_ready),
      .rm            (rm),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .dout          (dout),
      .iters         (iters)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Modulus unit: remainder captured at the request handshake.
   always @(posedge clk) begin
      if (mod_req_valid && mod_req_ready && dv != '0)
         rm <= dd % dv;
   end

   // Ready/valid of the modulus unit, updated mid-cycle with optional stalls.
   always @(negedge clk) begin
      if (mod_req_valid) begin
         if (req_cnt_r < req_stall) begin
            mod_req_ready = 1'b0;
            req_cnt_r     = req_cnt_r + 1;
         end else begin
            mod_req_ready = 1'b1;
            req_cnt_r     = 0;
         end
      end else begin
         mod_req_ready = 1'b0;
         req_cnt_r     = 0;
      end
      if (mod_rsp_ready) begin
         if (rsp_cnt_r < rsp_delay) begin
            mod_rsp_valid = 1'b0;
            rsp_cnt_r     = rsp_cnt_r + 1;
         end else begin
            mod_rsp_valid = 1'b1;
         end
      end else begin
         mod_rsp_valid = 1'b0;
         rsp_cnt_r     = 0;
      end
   end

   // Runs one operation from idle. lat counts edges after the accepting edge
   // until out_valid is seen (-1 on timeout). bad counts protocol violations.
   task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input int out_hold,
                        output logic [W-1:0] got_dout, output logic [C-1:0] got_iters,
                        output int o_lat, output int o_nreq,
                        output logic [W-1:0] first_dd, output logic [W-1:0] first_dv,
                        output int o_bad);
      logic         prev_v;
      logic [W-1:0] pdd;
      logic [W-1:0] pdv;
      o_lat = -1; o_nreq = 0; o_bad = 0;
      first_dd = '0; first_dv = '0; got_dout = '0; got_iters = '0;
      prev_v = 1'b0; pdd = '0; pdv = '0;
      @(negedge clk);
      if (!in_ready) o_bad++;
      in_valid = 1'b1; a = op_a; b = op_b;
      @(posedge clk);
      #1 in_valid = 1'b0; a = '0; b = '0;
      for (int m = 0; m < 400 && o_lat < 0; m++) begin
         @(negedge clk);
         if (!mod_req_valid && (dd != '0 || dv != '0)) o_bad++;
         if (!out_valid && (dout != '0 || iters != '0)) o_bad++;
         if (in_ready) o_bad++;
         if (mod_req_valid) begin
            if (!prev_v) begin
               o_nreq++;
               if (o_nreq == 1) begin first_dd = dd; first_dv = dv; end
            end else if (dd != pdd || dv != pdv) begin
               o_bad++;
            end
         end
         prev_v = mod_req_valid; pdd = dd; pdv = dv;
         if (out_valid) o_lat = m;
      end
      if (o_lat < 0) return;
      got_dout = dout; got_iters = iters;
      for (int h = 1; h < out_hold; h++) begin
         @(negedge clk);
         if (!out_valid || dout != got_dout || iters != got_iters || in_ready) o_bad++;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      if (!in_ready || out_valid) o_bad++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL reset_in_ready: got %b exp 1", in_ready);
      end
      tests_run++;
      if ({mod_req_valid, mod_rsp_ready, out_valid} !== 3'b000) begin
         tests_failed++; $display("FAIL reset_valids: got %b exp 000", {mod_req_valid, mod_rsp_ready, out_valid});
      end
      tests_run++;
      if ((dd | dv | dout) !== '0 || iters !== '0) begin
         tests_failed++; $display("FAIL reset_buses: dd=%0d dv=%0d dout=%0d iters=%0d exp all 0", dd, dv, dout, iters);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic();
      do_op(32'd48, 32'd18, 0, gd, gi, lat, nreq, fdd, fdv, bad);
      tests_run++;
      if (gd !== 32'd6 || gi !== 2'd3) begin
         tests_failed++; $display("FAIL basic_result: got dout=%0d iters=%0d exp 6/3", gd, gi);
      end
      // SEND,WAIT,CHECK,SWAP per iteration, last one without SWAP: 4*3-1
      tests_run++;
      if (lat !== 11) begin
         tests_failed++; $display("FAIL basic_latency: got %0d exp 11", lat);
      end
      tests_run++;
      if (nreq !== 3 || bad !== 0) begin
         tests_failed++; $display("FAIL basic_protocol: got nreq=%0d bad=%0d exp 3/0", nreq, bad);
      end
   endtask

   task automatic test_swap();
      do_op(32'd18, 32'd48, 0, gd, gi, lat, nreq, fdd, fdv, bad);
      tests_run++;
      if (gd !== 32'd6 || gi !== 2'd3) begin
         tests_failed++; $display("FAIL swap_result: got dout=%0d iters=%0d exp 6/3", gd, gi);
      end
      tests_run++;
      if (fdd !== 32'd48 || fdv !== 32'd18) begin
         tests_failed++; $display("FAIL swap_first_req: got dd=%0d dv=%0d exp 48/18", fdd, fdv);
      end
   endtask

   task automatic test_zero();
      do_op(32'd0, 32'd37, 0, gd, gi, lat, nreq, fdd, fdv, bad);
      tests_run++;
      if (gd !== 32'd37 || gi !== 2'd0 || nreq !== 0) begin
         tests_failed++; $display("FAIL zero_a: got dout=%0d iters=%0d nreq=%0d exp 37/0/0", gd, gi, nreq);
      end
      tests_run++;
      if (lat !== 0 || bad !== 0) begin
         tests_failed++; $display("FAIL zero_a_timing: got lat=%0d bad=%0d exp 0/0", lat, bad);
      end
      do_op(32'd0, 32'd0, 0, gd, gi, lat, nreq, fdd, fdv, bad);
      tests_run++;
      if (gd !== 32'd0 || gi !== 2'd0 || nreq !== 0 || lat !== 0) begin
         tests_failed++; $display("FAIL zero_both: got dout=%0d iters=%0d nreq=%0d lat=%0d exp 0/0/0/0", gd, gi, nreq, lat);
      end
      do_op(32'd37, 32'd0, 0, gd, gi, lat, nreq, fdd, fdv, bad);
      tests_run++;
      if (gd !== 32'd37 || nreq !== 0) begin
         tests_failed++; $display("FAIL zero_b: got dout=%0d nreq=%0d exp 37/0", gd, nreq);
      end
   endtask

   task automatic test_stall();
      req_stall = 3; rsp_delay = 5;
      do_op(32'd17, 32'd5, 4, gd, gi, lat, nreq, fdd, fdv, bad);
      req_stall = 0; rsp_delay = 0;
      tests_run++;
      if (gd !== 32'd1 || gi !== 2'd3) begin
         tests_failed++; $display("FAIL stall_result: got dout=%0d iters=%0d exp 1/3", gd, gi);
      end
      // 11 base cycles plus 3 request-stall and 5 response-wait cycles per iteration
      tests_run++;
      if (lat !== 35) begin
         tests_failed++; $display("FAIL stall_latency: got %0d exp 35", lat);
      end
      tests_run++;
      if (bad !== 0 || nreq !== 3) begin
         tests_failed++; $display("FAIL stall_protocol: got bad=%0d nreq=%0d exp 0/3", bad, nreq);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      seen = 0;
      rsp_delay = 10;
      @(negedge clk);
      in_valid = 1'b1; a = 32'd1000; b = 32'd7;
      @(posedge clk);
      #1 in_valid = 1'b0; a = '0; b = '0;
      for (int m = 0; m < 20 && seen == 0; m++) begin
         @(negedge clk);
         if (mod_rsp_ready) seen = 1;
      end
      tests_run++;
      if (seen !== 1) begin
         tests_failed++; $display("FAIL reset_mid_wait: got wait_seen=%0d exp 1", seen);
      end
      reset = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1 || {mod_req_valid, mod_rsp_ready, out_valid} !== 3'b000) begin
         tests_failed++; $display("FAIL reset_mid_ctrl: got in_ready=%b valids=%b exp 1/000", in_ready, {mod_req_valid, mod_rsp_ready, out_valid});
      end
      @(negedge clk);
      tests_run++;
      if ((dd | dv | dout) !== '0 || iters !== '0 || in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL reset_mid_buses: dd=%0d dv=%0d dout=%0d iters=%0d in_ready=%b exp 0/0/0/0/1", dd, dv, dout, iters, in_ready);
      end
      reset = 1'b0;
      rsp_delay = 0;
      do_op(32'd12, 32'd8, 0, gd, gi, lat, nreq, fdd, fdv, bad);
      tests_run++;
      if (gd !== 32'd4 || gi !== 2'd2 || lat !== 7) begin
         tests_failed++; $display("FAIL after_reset: got dout=%0d iters=%0d lat=%0d exp 4/2/7", gd, gi, lat);
      end
   endtask

   task automatic test_saturate();
      // 13,8 needs 5 modulus operations; a 2-bit counter stops at 3
      do_op(32'd13, 32'd8, 0, gd, gi, lat, nreq, fdd, fdv, bad);
      tests_run++;
      if (gd !== 32'd1 || gi !== 2'd3 || nreq !== 5) begin
         tests_failed++; $display("FAIL saturate: got dout=%0d iters=%0d nreq=%0d exp 1/3/5", gd, gi, nreq);
      end
      tests_run++;
      if (lat !== 19) begin
         tests_failed++; $display("FAIL saturate_latency: got %0d exp 19", lat);
      end
   endtask

   task automatic test_wide();
      do_op(32'hFFFF_FFFE, 32'h7FFF_FFFF, 0, gd, gi, lat, nreq, fdd, fdv, bad);
      tests_run++;
      if (gd !== 32'h7FFF_FFFF || gi !== 2'd1 || lat !== 3) begin
         tests_failed++; $display("FAIL wide: got dout=%h iters=%0d lat=%0d exp 7fffffff/1/3", gd, gi, lat);
      end
      tests_run++;
      if (fdd !== 32'hFFFF_FFFE || fdv !== 32'h7FFF_FFFF) begin
         tests_failed++; $display("FAIL wide_order: got dd=%h dv=%h exp fffffffe/7fffffff", fdd, fdv);
      end
   endtask

   task automatic test_back_to_back();
      int early;
      int got1;
      early = 0; got1 = 0;
      @(negedge clk);
      in_valid = 1'b1; a = 32'd48; b = 32'd18;
      @(posedge clk);
      #1 a = 32'd12; b = 32'd8;
      for (int m = 0; m < 100 && got1 == 0; m++) begin
         @(negedge clk);
         if (in_ready) early++;
         if (out_valid) got1 = 1;
      end
      tests_run++;
      if (got1 !== 1 || dout !== 32'd6 || early !== 0) begin
         tests_failed++; $display("FAIL b2b_first: got done=%0d dout=%0d early_ready=%0d exp 1/6/0", got1, dout, early);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL b2b_idle: got in_ready=%b exp 1", in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0; a = '0; b = '0;
      tests_run++;
      if (in_ready !== 1'b0 || mod_req_valid !== 1'b1 || dd !== 32'd12 || dv !== 32'd8) begin
         tests_failed++; $display("FAIL b2b_second_accept: got in_ready=%b req=%b dd=%0d dv=%0d exp 0/1/12/8", in_ready, mod_req_valid, dd, dv);
      end
      got1 = 0;
      for (int m = 0; m < 100 && got1 == 0; m++) begin
         @(negedge clk);
         if (out_valid) got1 = 1;
      end
      tests_run++;
      if (got1 !== 1 || dout !== 32'd4 || iters !== 2'd2) begin
         tests_failed++; $display("FAIL b2b_second: got done=%0d dout=%0d iters=%0d exp 1/4/2", got1, dout, iters);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   initial begin
      tests_run = 0; tests_failed = 0;
      req_stall = 0; rsp_delay = 0; req_cnt_r = 0; rsp_cnt_r = 0;
      in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
      mod_req_ready = 1'b0; mod_rsp_valid = 1'b0; rm = '0;
      reset = 1'b1;
      test_reset();
      test_basic();
      test_swap();
      test_zero();
      test_stall();
      test_reset_mid();
      test_saturate();
      test_wide();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
